// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the button debounce bank: state encoding,
// inactive-level derivation and counter sizing.
package btn_debounce_pkg;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } btn_state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Raw pin level seen when the button is not pressed.
    function automatic logic inactive_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single debounced button: two-flop synchroniser, stability counter, RELEASED/PRESSED
// FSM and registered press/release pulses. Auto-repeat is built when BTN_AUTO_REPEAT_EN is defined.
module debounce_channel
    import btn_debounce_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic state,
    output logic press,
    output logic rel
);

    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    localparam logic             IDLE_LVL = inactive_level(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_p0, sync_p1;
    logic             sample;
    btn_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    // Stage p0/p1: synchroniser, preloaded with the idle level so reset never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = sync_p1 ^ IDLE_LVL;

    always_comb begin
        st_d    = st_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sample != logic'(st_q)) begin
            if (cnt_q == CNT_MAX) begin
                st_d    = btn_state_e'(sample);
                press_d = sample;
                rel_d   = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef BTN_AUTO_REPEAT_EN
        // Count down while held; a release or a fresh press overrides any pending repeat.
        rpt_d = '0;
        if (st_q == PRESSED && st_d == PRESSED) begin
            if (rpt_q == '0) begin
                press_d = 1'b1;
                rpt_d   = RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end else if (st_d == PRESSED) begin
            rpt_d = RPT_W'(REPEAT_DELAY - 1);
        end
`endif
    end

    // Stage p2: debounced state, counter and one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign state = (st_q == PRESSED);
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of NUM_CH independent button debouncers with one-cycle press/release pulses.
// Optional auto-repeat of btn_press is enabled by defining BTN_AUTO_REPEAT_EN.
module button_debounce_bank
    import btn_debounce_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .state(btn_state[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i])
        );
    end

endmodule
